// File: rtl/painterengine_gpu_pkg.sv
// rtl/painterengine_gpu_pkg.sv - shared DMA state encodings and AXI constants
package painterengine_gpu_pkg;

    localparam logic [2:0] DMA_IDLE  = 3'd0;
    localparam logic [2:0] DMA_ADDR  = 3'd1;
    localparam logic [2:0] DMA_DATA  = 3'd2;
    localparam logic [2:0] DMA_DRAIN = 3'd3;
    localparam logic [2:0] DMA_DONE  = 3'd4;
    localparam logic [2:0] DMA_ERROR = 3'd5;

    localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
    localparam logic [2:0]  AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
    localparam logic [12:0] PAGE_SIZE      = 13'h1000;

endpackage

// File: rtl/painterengine_gpu_burst_calc.sv
// rtl/painterengine_gpu_burst_calc.sv - burst length limited by remaining words, max burst and 4 KB page
module painterengine_gpu_burst_calc
    import painterengine_gpu_pkg::*;
#(
    parameter int PARAM_MAX_BURST = 16
) (
    input  logic [11:0] i_cur_addr_lo,
    input  logic [31:0] i_remaining,
    output logic [8:0]  o_beats,
    output logic [7:0]  o_arlen
);

    localparam logic [8:0] MAX_BEATS = 9'(PARAM_MAX_BURST);

    logic [10:0] page_beats;
    logic [8:0]  page_sat;
    logic [8:0]  rem_sat;
    logic [8:0]  beats;

    always_comb begin
        // Words left before the next 4 KB boundary: 1..1024.
        page_beats = 11'((PAGE_SIZE - {1'b0, i_cur_addr_lo}) >> 2);
        page_sat   = (page_beats > 11'd256) ? 9'd256 : page_beats[8:0];
        rem_sat    = (i_remaining > 32'd256) ? 9'd256 : i_remaining[8:0];
        beats      = MAX_BEATS;
        if (page_sat < beats) beats = page_sat;
        if (rem_sat < beats)  beats = rem_sat;
        o_beats = beats;
        o_arlen = 8'(beats - 9'd1);
    end

endmodule

// File: rtl/painterengine_gpu_dma_reader.sv
// rtl/painterengine_gpu_dma_reader.sv - AXI4 read master feeding the display DMA reader port
module painterengine_gpu_dma_reader
    import painterengine_gpu_pkg::*;
#(
    parameter int PARAM_MAX_BURST  = 16,
    parameter int PARAM_ADDR_WIDTH = 32
) (
    input  logic                        i_wire_clock,
    input  logic                        i_wire_resetn,
    input  logic [PARAM_ADDR_WIDTH-1:0] i_wire_reader_address,
    input  logic [31:0]                 i_wire_reader_length,
    input  logic                        i_wire_reader_resetn,
    output logic                        o_wire_reader_done,
    output logic                        o_wire_reader_error,
    output logic [31:0]                 o_wire_reader_data,
    output logic                        o_wire_reader_data_valid,
    input  logic                        i_wire_reader_data_next,
    output logic [PARAM_ADDR_WIDTH-1:0] o_wire_m_axi_araddr,
    output logic [7:0]                  o_wire_m_axi_arlen,
    output logic [2:0]                  o_wire_m_axi_arsize,
    output logic [1:0]                  o_wire_m_axi_arburst,
    output logic                        o_wire_m_axi_arvalid,
    input  logic                        i_wire_m_axi_arready,
    input  logic [31:0]                 i_wire_m_axi_rdata,
    input  logic [1:0]                  i_wire_m_axi_rresp,
    input  logic                        i_wire_m_axi_rlast,
    input  logic                        i_wire_m_axi_rvalid,
    output logic                        o_wire_m_axi_rready
);

    logic [2:0]                  state_q, state_d;
    logic [PARAM_ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [31:0]                 remaining_q, remaining_d;
    logic                        err_q, err_d;
    logic                        abort_q, abort_d;
    logic [8:0]                  beats;
    logic [7:0]                  burst_arlen;
    logic                        r_hs;
    logic                        r_bad;

    painterengine_gpu_burst_calc #(
        .PARAM_MAX_BURST(PARAM_MAX_BURST)
    ) u_burst_calc (
        .i_cur_addr_lo(cur_addr_q[11:0]),
        .i_remaining  (remaining_q),
        .o_beats      (beats),
        .o_arlen      (burst_arlen)
    );

    always_comb begin
        state_d                  = state_q;
        cur_addr_d               = cur_addr_q;
        remaining_d              = remaining_q;
        err_d                    = err_q;
        abort_d                  = abort_q;
        o_wire_m_axi_arvalid     = 1'b0;
        o_wire_m_axi_rready      = 1'b0;
        o_wire_reader_data_valid = 1'b0;
        r_hs                     = 1'b0;
        r_bad                    = 1'b0;
        case (state_q)
            DMA_IDLE: begin
                err_d   = 1'b0;
                abort_d = 1'b0;
                if (i_wire_reader_resetn) begin
                    cur_addr_d  = i_wire_reader_address;
                    remaining_d = i_wire_reader_length;
                    if (i_wire_reader_length == 32'd0)           state_d = DMA_DONE;
                    else if (i_wire_reader_address[1:0] != 2'b00) state_d = DMA_ERROR;
                    else                                          state_d = DMA_ADDR;
                end
            end
            DMA_ADDR: begin
                // An issued AR cannot be withdrawn, so an abort is remembered until the handshake.
                o_wire_m_axi_arvalid = 1'b1;
                if (!i_wire_reader_resetn) abort_d = 1'b1;
                if (i_wire_m_axi_arready) begin
                    cur_addr_d  = cur_addr_q + PARAM_ADDR_WIDTH'({beats, 2'b00});
                    remaining_d = remaining_q - {23'd0, beats};
                    state_d     = (abort_q || !i_wire_reader_resetn) ? DMA_DRAIN : DMA_DATA;
                end
            end
            DMA_DATA: begin
                o_wire_m_axi_rready = err_q || !i_wire_reader_resetn || i_wire_reader_data_next;
                r_hs  = i_wire_m_axi_rvalid && o_wire_m_axi_rready;
                r_bad = i_wire_m_axi_rresp != AXI_RESP_OKAY;
                if (!i_wire_reader_resetn) begin
                    state_d = (r_hs && i_wire_m_axi_rlast) ? DMA_IDLE : DMA_DRAIN;
                end else if (r_hs) begin
                    o_wire_reader_data_valid = !err_q && !r_bad;
                    if (r_bad) err_d = 1'b1;
                    if (i_wire_m_axi_rlast) begin
                        if (err_q || r_bad)            state_d = DMA_ERROR;
                        else if (remaining_q == 32'd0) state_d = DMA_DONE;
                        else                           state_d = DMA_ADDR;
                    end
                end
            end
            DMA_DRAIN: begin
                o_wire_m_axi_rready = 1'b1;
                if (i_wire_m_axi_rvalid && i_wire_m_axi_rlast) state_d = DMA_IDLE;
            end
            DMA_DONE, DMA_ERROR: begin
                if (!i_wire_reader_resetn) state_d = DMA_IDLE;
            end
            default: state_d = DMA_IDLE;
        endcase
    end

    always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
        if (!i_wire_resetn) begin
            state_q     <= DMA_IDLE;
            cur_addr_q  <= '0;
            remaining_q <= 32'd0;
            err_q       <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            err_q       <= err_d;
            abort_q     <= abort_d;
        end
    end

    assign o_wire_reader_done   = state_q == DMA_DONE;
    assign o_wire_reader_error  = state_q == DMA_ERROR;
    assign o_wire_reader_data   = o_wire_reader_data_valid ? i_wire_m_axi_rdata : 32'd0;
    assign o_wire_m_axi_araddr  = o_wire_m_axi_arvalid ? cur_addr_q : '0;
    assign o_wire_m_axi_arlen   = o_wire_m_axi_arvalid ? burst_arlen : 8'd0;
    assign o_wire_m_axi_arsize  = AXI_SIZE_4B;
    assign o_wire_m_axi_arburst = AXI_BURST_INCR;

endmodule

// File: tb/tb_painterengine_gpu_dma_reader.sv
// tb/tb_painterengine_gpu_dma_reader.sv - job-table and random-job bench with AXI slave and reference model
module tb_painterengine_gpu_dma_reader;

    logic        clk = 1'b0;
    logic        i_wire_resetn;
    logic [31:0] i_wire_reader_address;
    logic [31:0] i_wire_reader_length;
    logic        i_wire_reader_resetn;
    logic        o_wire_reader_done;
    logic        o_wire_reader_error;
    logic [31:0] o_wire_reader_data;
    logic        o_wire_reader_data_valid;
    logic        i_wire_reader_data_next;
    logic [31:0] o_wire_m_axi_araddr;
    logic [7:0]  o_wire_m_axi_arlen;
    logic [2:0]  o_wire_m_axi_arsize;
    logic [1:0]  o_wire_m_axi_arburst;
    logic        o_wire_m_axi_arvalid;
    logic        i_wire_m_axi_arready;
    logic [31:0] i_wire_m_axi_rdata;
    logic [1:0]  i_wire_m_axi_rresp;
    logic        i_wire_m_axi_rlast;
    logic        i_wire_m_axi_rvalid;
    logic        o_wire_m_axi_rready;

    always #5 clk = ~clk;

    painterengine_gpu_dma_reader dut (
        .i_wire_clock            (clk),
        .i_wire_resetn           (i_wire_resetn),
        .i_wire_reader_address   (i_wire_reader_address),
        .i_wire_reader_length    (i_wire_reader_length),
        .i_wire_reader_resetn    (i_wire_reader_resetn),
        .o_wire_reader_done      (o_wire_reader_done),
        .o_wire_reader_error     (o_wire_reader_error),
        .o_wire_reader_data      (o_wire_reader_data),
        .o_wire_reader_data_valid(o_wire_reader_data_valid),
        .i_wire_reader_data_next (i_wire_reader_data_next),
        .o_wire_m_axi_araddr     (o_wire_m_axi_araddr),
        .o_wire_m_axi_arlen      (o_wire_m_axi_arlen),
        .o_wire_m_axi_arsize     (o_wire_m_axi_arsize),
        .o_wire_m_axi_arburst    (o_wire_m_axi_arburst),
        .o_wire_m_axi_arvalid    (o_wire_m_axi_arvalid),
        .i_wire_m_axi_arready    (i_wire_m_axi_arready),
        .i_wire_m_axi_rdata      (i_wire_m_axi_rdata),
        .i_wire_m_axi_rresp      (i_wire_m_axi_rresp),
        .i_wire_m_axi_rlast      (i_wire_m_axi_rlast),
        .i_wire_m_axi_rvalid     (i_wire_m_axi_rvalid),
        .o_wire_m_axi_rready     (o_wire_m_axi_rready)
    );

    typedef struct {
        logic [31:0] addr;
        int          len;
        int          mode;      // data_next: 0 always, 1 one-in-three, 2 random
        bit          ar_rand;   // random arready/rvalid
        int          err_beat;  // job beat index answered with SLVERR, -1 none
        int          exp_words;
        int          exp_ars;
        bit          exp_done;
        bit          exp_err;
    } job_t;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_ar_a[$];
    int          exp_ar_l[$];
    bit          s_active, rv_hold, ar_rand;
    logic [31:0] s_addr, job_addr;
    int          s_left, job_beat, err_beat, dn_mode, wcount, ar_cnt, cyc;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h00C0_FFEE;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: split the job into page-safe bursts of at most 16 words.
    task automatic model_job(input logic [31:0] a, input int len, input int eb,
                             output int nw, output int nar, output bit dn, output bit er);
        int rem, idx, pg, b;
        logic [31:0] cur;
        exp_ar_a.delete();
        exp_ar_l.delete();
        nw = 0; nar = 0; dn = 0; er = 0;
        if (len == 0) begin dn = 1; return; end
        if (a[1:0] != 2'b00) begin er = 1; return; end
        rem = len; idx = 0; cur = a; nw = len; dn = 1;
        while (rem > 0) begin
            pg = (4096 - int'(cur[11:0])) / 4;
            b  = (rem < 16) ? rem : 16;
            if (pg < b) b = pg;
            exp_ar_a.push_back(cur);
            exp_ar_l.push_back(b - 1);
            if (eb >= idx && eb < idx + b) begin
                nw = eb; dn = 0; er = 1; rem = 0;
            end else begin
                idx += b; rem -= b; cur = cur + 32'(4 * b);
            end
        end
        nar = exp_ar_a.size();
    endtask

    task automatic step(input bit rn);
        @(negedge clk);
        i_wire_reader_resetn = rn;
        i_wire_m_axi_arready = ar_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (!s_active)     i_wire_m_axi_rvalid = 1'b0;
        else if (!rv_hold) i_wire_m_axi_rvalid = ar_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
        i_wire_m_axi_rdata = memf(s_addr);
        i_wire_m_axi_rresp = (job_beat == err_beat) ? 2'b10 : 2'b00;
        i_wire_m_axi_rlast = s_active && (s_left == 1);
        case (dn_mode)
            0:       i_wire_reader_data_next = 1'b1;
            1:       i_wire_reader_data_next = (cyc % 3 == 0);
            default: i_wire_reader_data_next = 1'($urandom_range(0, 1));
        endcase
        #1;
        if (o_wire_reader_data_valid) begin
            check("data_next_gate", i_wire_reader_data_next, 1);
            check("word", o_wire_reader_data, memf(job_addr + 32'(wcount) * 32'd4));
            wcount++;
        end
        if (i_wire_m_axi_rvalid && o_wire_m_axi_rready) begin
            s_addr += 4; s_left--; job_beat++; rv_hold = 0;
            if (s_left == 0) s_active = 0;
        end else begin
            rv_hold = i_wire_m_axi_rvalid;
        end
        if (o_wire_m_axi_arvalid && i_wire_m_axi_arready) begin
            check("ar_single_outstanding", s_active, 0);
            if (ar_cnt < exp_ar_a.size()) begin
                check("ar_addr", o_wire_m_axi_araddr, exp_ar_a[ar_cnt]);
                check("ar_len", o_wire_m_axi_arlen, exp_ar_l[ar_cnt]);
            end else begin
                check("extra_ar", ar_cnt + 1, exp_ar_a.size());
            end
            ar_cnt++;
            s_active = 1; s_addr = o_wire_m_axi_araddr; s_left = int'(o_wire_m_axi_arlen) + 1;
        end
        cyc++;
    endtask

    task automatic run_job(input job_t j, input int abort_after);
        int nw, nar, dcyc, quiet, aw;
        bit dn, er, fin;
        model_job(j.addr, j.len, j.err_beat, nw, nar, dn, er);
        i_wire_reader_address = j.addr;
        i_wire_reader_length  = j.len;
        ar_rand = j.ar_rand; dn_mode = j.mode; err_beat = j.err_beat;
        wcount = 0; ar_cnt = 0; job_beat = 0; job_addr = j.addr; cyc = 0;
        fin = 0; dcyc = -1;
        for (int c = 0; c < 3000 && !fin; c++) begin
            step(1'b1);
            if (o_wire_reader_done || o_wire_reader_error) begin fin = 1; dcyc = c; end
            if (abort_after >= 0 && wcount >= abort_after) fin = 1;
        end
        check("job_finished", fin, 1);
        if (abort_after >= 0) begin
            aw = wcount; quiet = 0;
            for (int c = 0; c < 500 && quiet < 4; c++) begin
                step(1'b0);
                if (o_wire_reader_done || o_wire_reader_error)
                    check("abort_flags_low", {o_wire_reader_done, o_wire_reader_error}, 0);
                if (!s_active && !o_wire_m_axi_arvalid) quiet++; else quiet = 0;
            end
            check("abort_quiet", quiet, 4);
            check("abort_no_more_words", wcount, aw);
            return;
        end
        if (j.len == 0 || j.addr[1:0] != 2'b00) check("immediate_flag_latency", dcyc, 1);
        for (int c = 0; c < 3; c++) begin
            step(1'b1);
            check("flags_hold", {o_wire_reader_done, o_wire_reader_error}, {j.exp_done, j.exp_err});
        end
        check("word_count", wcount, j.exp_words);
        check("ar_count", ar_cnt, j.exp_ars);
        step(1'b0);
        step(1'b0);
        check("flags_cleared", {o_wire_reader_done, o_wire_reader_error}, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        job_t tbl[$];
        job_t j;
        logic [31:0] r;
        int nw, nar;
        bit dn, er;

        //            addr          len mode ar  err  words ars done err
        tbl.push_back('{32'h1000_0000, 64, 0, 0, -1, 64, 4, 1, 0});
        tbl.push_back('{32'h0000_0FF8,  8, 0, 0, -1,  8, 2, 1, 0});
        tbl.push_back('{32'h0000_3000, 20, 1, 0, -1, 20, 2, 1, 0});
        tbl.push_back('{32'h0000_4000, 32, 0, 0,  3,  3, 1, 0, 1});
        tbl.push_back('{32'h0000_6000,  0, 0, 0, -1,  0, 0, 1, 0});
        tbl.push_back('{32'h0000_1002,  4, 0, 0, -1,  0, 0, 0, 1});
        tbl.push_back('{32'hFFFF_FFF0,  8, 2, 1, -1,  8, 2, 1, 0});

        s_active = 0; rv_hold = 0; ar_rand = 0; s_addr = 0; s_left = 0;
        job_beat = 0; err_beat = -1; dn_mode = 0; wcount = 0; ar_cnt = 0; cyc = 0; job_addr = 0;
        i_wire_resetn = 0; i_wire_reader_resetn = 0; i_wire_reader_address = 0; i_wire_reader_length = 0;
        i_wire_reader_data_next = 0; i_wire_m_axi_arready = 0; i_wire_m_axi_rdata = 0;
        i_wire_m_axi_rresp = 0; i_wire_m_axi_rlast = 0; i_wire_m_axi_rvalid = 0;
        repeat (2) @(negedge clk);
        check("reset_flags", {o_wire_reader_done, o_wire_reader_error, o_wire_reader_data_valid,
                              o_wire_m_axi_arvalid, o_wire_m_axi_rready}, 0);
        check("reset_addr_len", {o_wire_m_axi_araddr, o_wire_m_axi_arlen}, 0);
        check("reset_data", o_wire_reader_data, 0);
        check("axi_consts", {o_wire_m_axi_arsize, o_wire_m_axi_arburst}, {3'b010, 2'b01});
        i_wire_resetn = 1;
        step(1'b0);

        foreach (tbl[k]) run_job(tbl[k], -1);

        // Abort in the second burst, then a fresh job must run cleanly.
        run_job('{32'h1000_0000, 64, 0, 0, -1, 0, 0, 0, 0}, 20);
        run_job('{32'h0000_2000, 4, 0, 0, -1, 4, 1, 1, 0}, -1);

        // Asynchronous reset in the middle of a data burst.
        i_wire_reader_address = 32'h0000_5000; i_wire_reader_length = 32;
        void'(exp_ar_a.size());
        model_job(32'h0000_5000, 32, -1, nw, nar, dn, er);
        ar_rand = 0; dn_mode = 0; err_beat = -1; wcount = 0; ar_cnt = 0; job_beat = 0;
        job_addr = 32'h0000_5000; cyc = 0;
        for (int c = 0; c < 200 && wcount < 5; c++) step(1'b1);
        check("areset_setup_words", wcount, 5);
        @(negedge clk);
        #3 i_wire_resetn = 0;
        #1;
        check("areset_flags", {o_wire_reader_done, o_wire_reader_error, o_wire_reader_data_valid,
                               o_wire_m_axi_arvalid, o_wire_m_axi_rready}, 0);
        check("areset_addr_len", {o_wire_m_axi_araddr, o_wire_m_axi_arlen}, 0);
        check("areset_data", o_wire_reader_data, 0);
        s_active = 0; rv_hold = 0;
        step(1'b0);
        @(negedge clk);
        i_wire_resetn = 1;
        step(1'b0);

        for (int n = 0; n < 10; n++) begin
            r = $urandom();
            j.addr = {r[31:12], 12'h000};
            if ($urandom_range(0, 1) == 1) j.addr[11:0] = 12'(4096 - 4 * $urandom_range(1, 20));
            else                           j.addr[11:0] = 12'(4 * $urandom_range(0, 1023));
            j.len      = $urandom_range(1, 40);
            j.mode     = $urandom_range(0, 2);
            j.ar_rand  = 1;
            j.err_beat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, j.len - 1)) : -1;
            model_job(j.addr, j.len, j.err_beat, nw, nar, dn, er);
            j.exp_words = nw; j.exp_ars = nar; j.exp_done = dn; j.exp_err = er;
            run_job(j, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
